// File: rtl/reqack_arb_pkg.sv
// Shared types and constants for the req/ack concentrator.
package reqack_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  localparam int MODE_4PH = 0;
  localparam int MODE_2PH = 1;

  // Timeout counter width; a disabled timeout still gets one bit so the vector is legal.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/reqack_arb_if.sv
// Requester-side and downstream-side handshake bundle of the concentrator.
interface reqack_arb_if #(
  parameter int CH         = 4,
  parameter int DATA_WIDTH = 8
);

  logic [CH-1:0]            src_req;
  logic [CH*DATA_WIDTH-1:0] src_data;
  logic [CH-1:0]            src_busy;
  logic [CH-1:0]            src_ack;
  logic [CH-1:0]            src_err;
  logic [CH-1:0]            src_ovf;
  logic                     dst_req;
  logic [$clog2(CH)-1:0]    dst_ch;
  logic [DATA_WIDTH-1:0]    dst_data;
  logic                     dst_ack;

  // The concentrator itself.
  modport slave (
    input  src_req, src_data, dst_ack,
    output src_busy, src_ack, src_err, src_ovf, dst_req, dst_ch, dst_data
  );

  // Requesters plus downstream peer, as seen from outside.
  modport master (
    output src_req, src_data, dst_ack,
    input  src_busy, src_ack, src_err, src_ovf, dst_req, dst_ch, dst_data
  );

endinterface

// File: rtl/reqack_arb_rr_arbiter.sv
// Combinational round-robin picker: first pending channel at or after the pointer.
module rr_arbiter #(
  parameter int CH = 4
) (
  input  logic [CH-1:0]         i_pend,
  input  logic [$clog2(CH)-1:0] i_ptr,
  output logic [CH-1:0]         o_gnt,
  output logic [$clog2(CH)-1:0] o_idx,
  output logic                  o_any
);

  localparam int CHW = $clog2(CH);

  logic [CHW-1:0] w_cand [CH];

  // Candidate channel index for each offset from the pointer, wrapped modulo CH.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      w_cand[k] = CHW'((int'(i_ptr) + k) % CH);
    end
  end

  // Scan from the farthest offset back so the nearest pending candidate is the final assignment.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (i_pend[w_cand[k]]) begin
        o_gnt            = '0;
        o_gnt[w_cand[k]] = 1'b1;
        o_idx            = w_cand[k];
        o_any            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reqack_arb.sv
// Multi-channel req/ack concentrator: per-channel pending slots, round-robin
// issue onto one downstream four-phase or two-phase link, with timeout abort.
module reqack_arb
  import reqack_arb_pkg::*;
#(
  parameter int CH         = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MODE       = MODE_4PH,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rst,
  reqack_arb_if.slave  bus
);

  localparam int CHW  = $clog2(CH);
  localparam int CNTW = cnt_width(TIMEOUT);
  localparam logic [CNTW-1:0] TO_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CH-1:0]         r_pend;
  logic [DATA_WIDTH-1:0] r_slot [CH];
  logic [CHW-1:0]        r_rr_ptr;
  logic [CNTW-1:0]       r_cnt;
  logic                  r_dst_req;
  logic [CHW-1:0]        r_dst_ch;
  logic [DATA_WIDTH-1:0] r_dst_data;
  logic [CH-1:0]         r_ack;
  logic [CH-1:0]         r_err;
  logic [CH-1:0]         r_ovf;

  logic [CH-1:0]         w_gnt;
  logic [CHW-1:0]        w_gnt_idx;
  logic                  w_any;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic [CHW-1:0]        w_rr_nxt;
  logic                  w_link_idle;
  logic                  w_done;
  logic                  w_tmo;
  logic                  w_launch;
  logic [CH-1:0]         w_clr;
  logic [CH-1:0]         w_capture;
  logic [CH-1:0]         w_ovf;

  rr_arbiter #(.CH(CH)) u_rr (
    .i_pend (r_pend),
    .i_ptr  (r_rr_ptr),
    .o_gnt  (w_gnt),
    .o_idx  (w_gnt_idx),
    .o_any  (w_any)
  );

  // In two-phase mode the link is quiet and the transfer complete under the same condition: ack caught up with req.
  assign w_link_idle = (MODE == MODE_4PH) ? ~bus.dst_ack : (bus.dst_ack == r_dst_req);
  assign w_done      = (r_state == ST_REQ) &&
                       ((MODE == MODE_4PH) ? bus.dst_ack : (bus.dst_ack == r_dst_req));
  // Completion in the last allowed cycle beats the timeout.
  assign w_tmo       = (r_state == ST_REQ) && (TIMEOUT != 0) && (r_cnt == TO_LAST) && !w_done;
  assign w_rr_nxt    = (w_gnt_idx == CHW'(CH - 1)) ? '0 : (w_gnt_idx + 1'b1);

  // Payload of the granted slot, selected by the one-hot grant.
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (w_gnt[i]) w_gnt_data = r_slot[i];
    end
  end

  // Slot that finishes (ack or abort) this cycle; a new request may refill it at the same edge.
  always_comb begin
    w_clr = '0;
    if (w_done || w_tmo) w_clr[r_dst_ch] = 1'b1;
  end

  assign w_capture = bus.src_req & (~r_pend | w_clr);
  assign w_ovf     = bus.src_req & r_pend & ~w_clr;

  // Next-state logic of the issue FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any && w_link_idle) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_done || w_tmo) w_state_nxt = (MODE == MODE_4PH) ? ST_REL : ST_IDLE;
      end
      ST_REL: begin
        if (!bus.dst_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Pending flags and slot payloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      for (int i = 0; i < CH; i++) r_slot[i] <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_capture;
      for (int i = 0; i < CH; i++) begin
        if (w_capture[i]) r_slot[i] <= bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Downstream link registers, round-robin pointer and saturating timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst_req  <= 1'b0;
      r_dst_ch   <= '0;
      r_dst_data <= '0;
      r_rr_ptr   <= '0;
      r_cnt      <= '0;
    end else if (w_launch) begin
      r_dst_req  <= (MODE == MODE_4PH) ? 1'b1 : ~r_dst_req;
      r_dst_ch   <= w_gnt_idx;
      r_dst_data <= w_gnt_data;
      r_rr_ptr   <= w_rr_nxt;
      r_cnt      <= '0;
    end else if (r_state == ST_REQ) begin
      if ((w_done || w_tmo) && (MODE == MODE_4PH)) r_dst_req <= 1'b0;
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  // One-cycle status pulses back to the requesters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack <= '0;
      r_err <= '0;
      r_ovf <= '0;
    end else begin
      r_ack <= {CH{w_done}} & w_clr;
      r_err <= {CH{w_tmo}} & w_clr;
      r_ovf <= w_ovf;
    end
  end

  assign bus.src_busy = r_pend;
  assign bus.src_ack  = r_ack;
  assign bus.src_err  = r_err;
  assign bus.src_ovf  = r_ovf;
  assign bus.dst_req  = r_dst_req;
  assign bus.dst_ch   = r_dst_ch;
  assign bus.dst_data = r_dst_data;

endmodule

// File: tb/tb_reqack_arb.sv
// Bench for reqack_arb: a four-phase instance (TIMEOUT=8) and a two-phase
// instance (TIMEOUT=6) run side by side against a transaction-level model.
module tb_reqack_arb;

  localparam int CH = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reqack_arb_if #(.CH(CH), .DATA_WIDTH(DW)) bus0 ();
  reqack_arb_if #(.CH(CH), .DATA_WIDTH(DW)) bus1 ();

  reqack_arb #(.CH(CH), .DATA_WIDTH(DW), .MODE(0), .TIMEOUT(8)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );
  reqack_arb #(.CH(CH), .DATA_WIDTH(DW), .MODE(1), .TIMEOUT(6)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // stimulus and downstream responder state
  logic [3:0]  s_req  [2];
  logic [31:0] s_data [2];
  logic        s_ack  [2];
  bit          stall  [2];
  bit          rsp_busy [2];
  int          rsp_wait [2];
  int          dly_min [2];
  int          dly_max [2];
  logic        prev_dreq [2];

  // reference model state
  int          m_mode [2];
  int          m_to   [2];
  logic [3:0]  m_pend [2];
  logic [7:0]  m_slot [2][4];
  int          m_rr   [2];
  bit          m_inf  [2];
  bit          m_rel  [2];
  int          m_age  [2];
  logic        m_dreq [2];
  int          m_dch  [2];
  logic [7:0]  m_ddata[2];
  logic [3:0]  m_ack  [2];
  logic [3:0]  m_err  [2];
  logic [3:0]  m_ovf  [2];

  // observations from the DUTs
  int          n_ack [2][4];
  int          n_err [2][4];
  int          n_ovf [2][4];
  int          t_launch [2];
  int          t_err    [2];
  int          q_ch0 [$];
  logic [7:0]  q_data0 [$];
  logic        q_req1 [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic o_dreq(input int d);
    return (d == 0) ? bus0.dst_req : bus1.dst_req;
  endfunction
  function automatic logic [1:0] o_dch(input int d);
    return (d == 0) ? bus0.dst_ch : bus1.dst_ch;
  endfunction
  function automatic logic [7:0] o_ddata(input int d);
    return (d == 0) ? bus0.dst_data : bus1.dst_data;
  endfunction
  function automatic logic [3:0] o_busy(input int d);
    return (d == 0) ? bus0.src_busy : bus1.src_busy;
  endfunction
  function automatic logic [3:0] o_ack(input int d);
    return (d == 0) ? bus0.src_ack : bus1.src_ack;
  endfunction
  function automatic logic [3:0] o_err(input int d);
    return (d == 0) ? bus0.src_err : bus1.src_err;
  endfunction
  function automatic logic [3:0] o_ovf(input int d);
    return (d == 0) ? bus0.src_ovf : bus1.src_ovf;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = '0; m_rr[d] = 0; m_inf[d] = 0; m_rel[d] = 0; m_age[d] = 0;
      m_dreq[d] = 1'b0; m_dch[d] = 0; m_ddata[d] = '0;
      m_ack[d] = '0; m_err[d] = '0; m_ovf[d] = '0;
      for (int i = 0; i < CH; i++) m_slot[d][i] = '0;
    end
  endtask

  // One clock of the model: transfer bookkeeping first, then requests land in (possibly just freed) slots.
  task automatic m_step(input int d, input logic [3:0] req, input logic [31:0] data, input logic ack);
    int  freed;
    bit  done;
    bit  quiet;
    int  c;
    freed = -1;
    m_ack[d] = '0; m_err[d] = '0; m_ovf[d] = '0;
    if (m_inf[d]) begin
      done = (m_mode[d] == 0) ? (ack == 1'b1) : (ack == m_dreq[d]);
      if (done || (m_to[d] != 0 && m_age[d] == m_to[d] - 1)) begin
        if (done) m_ack[d][m_dch[d]] = 1'b1;
        else      m_err[d][m_dch[d]] = 1'b1;
        freed    = m_dch[d];
        m_inf[d] = 0;
        if (m_mode[d] == 0) begin
          m_dreq[d] = 1'b0;
          m_rel[d]  = 1;
        end
      end else if (m_age[d] < 100000) begin
        m_age[d]++;
      end
    end else if (m_rel[d]) begin
      if (ack == 1'b0) m_rel[d] = 0;
    end else begin
      quiet = (m_mode[d] == 0) ? (ack == 1'b0) : (ack == m_dreq[d]);
      if (quiet) begin
        for (int k = 0; k < CH; k++) begin
          c = (m_rr[d] + k) % CH;
          if (m_pend[d][c] && !m_inf[d]) begin
            m_inf[d]   = 1;
            m_dch[d]   = c;
            m_ddata[d] = m_slot[d][c];
            m_dreq[d]  = (m_mode[d] == 0) ? 1'b1 : ~m_dreq[d];
            m_age[d]   = 0;
            m_rr[d]    = (c + 1) % CH;
          end
        end
      end
    end
    if (freed >= 0) m_pend[d][freed] = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (req[i]) begin
        if (m_pend[d][i]) m_ovf[d][i] = 1'b1;
        else begin
          m_slot[d][i] = data[i*8 +: 8];
          m_pend[d][i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare(input int d, input string ph);
    chk($sformatf("%s.d%0d.dst_req", ph, d),  32'(o_dreq(d)),  32'(m_dreq[d]));
    chk($sformatf("%s.d%0d.dst_ch", ph, d),   32'(o_dch(d)),   32'(m_dch[d]));
    chk($sformatf("%s.d%0d.dst_data", ph, d), 32'(o_ddata(d)), 32'(m_ddata[d]));
    chk($sformatf("%s.d%0d.src_busy", ph, d), 32'(o_busy(d)),  32'(m_pend[d]));
    chk($sformatf("%s.d%0d.src_ack", ph, d),  32'(o_ack(d)),   32'(m_ack[d]));
    chk($sformatf("%s.d%0d.src_err", ph, d),  32'(o_err(d)),   32'(m_err[d]));
    chk($sformatf("%s.d%0d.src_ovf", ph, d),  32'(o_ovf(d)),   32'(m_ovf[d]));
  endtask

  task automatic log_out(input int d);
    logic [3:0] a, e, o;
    logic       cur;
    bit         launched;
    a = o_ack(d); e = o_err(d); o = o_ovf(d); cur = o_dreq(d);
    launched = (d == 0) ? (!prev_dreq[d] && cur) : (prev_dreq[d] != cur);
    if (launched) begin
      t_launch[d] = cyc;
      if (d == 0) begin
        q_ch0.push_back(int'(o_dch(d)));
        q_data0.push_back(o_ddata(d));
      end else begin
        q_req1.push_back(cur);
      end
    end
    for (int i = 0; i < CH; i++) begin
      n_ack[d][i] += int'(a[i]);
      n_err[d][i] += int'(e[i]);
      n_ovf[d][i] += int'(o[i]);
      if (e[i]) t_err[d] = cyc;
    end
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      t_launch[d] = -1; t_err[d] = -1;
      for (int i = 0; i < CH; i++) begin
        n_ack[d][i] = 0; n_err[d][i] = 0; n_ovf[d][i] = 0;
      end
    end
    q_ch0.delete(); q_data0.delete(); q_req1.delete();
  endtask

  task automatic drive();
    bus0.src_req = s_req[0]; bus0.src_data = s_data[0]; bus0.dst_ack = s_ack[0];
    bus1.src_req = s_req[1]; bus1.src_data = s_data[1]; bus1.dst_ack = s_ack[1];
  endtask

  // Downstream peer: ack follows req after a random delay, unless stalled.
  task automatic respond(input int d);
    logic want;
    bit   blocked;
    want    = o_dreq(d);
    blocked = stall[d] && (d == 1 || want == 1'b1);
    if (s_ack[d] != want && !blocked) begin
      if (!rsp_busy[d]) begin
        rsp_busy[d] = 1;
        rsp_wait[d] = $urandom_range(dly_max[d], dly_min[d]);
      end
      if (rsp_wait[d] == 0) begin
        s_ack[d]    = want;
        rsp_busy[d] = 0;
      end else begin
        rsp_wait[d]--;
      end
    end else begin
      rsp_busy[d] = 0;
    end
  endtask

  task automatic tick(input string ph);
    drive();
    prev_dreq[0] = bus0.dst_req;
    prev_dreq[1] = bus1.dst_req;
    @(posedge clk);
    cyc++;
    m_step(0, s_req[0], s_data[0], s_ack[0]);
    m_step(1, s_req[1], s_data[1], s_ack[1]);
    #1;
    compare(0, ph);
    compare(1, ph);
    log_out(0);
    log_out(1);
    s_req[0] = '0;
    s_req[1] = '0;
    respond(0);
    respond(1);
  endtask

  task automatic run(input int n, input string ph);
    repeat (n) tick(ph);
  endtask

  task automatic quiet_inputs();
    for (int d = 0; d < 2; d++) begin
      s_req[d] = '0; s_data[d] = '0; s_ack[d] = 1'b0;
      stall[d] = 0; rsp_busy[d] = 0; rsp_wait[d] = 0;
    end
    drive();
  endtask

  task automatic do_reset(input string ph);
    rst = 1'b1;
    quiet_inputs();
    m_reset();
    #1;
    compare(0, ph);
    compare(1, ph);
    @(posedge clk);
    #1;
    compare(0, ph);
    compare(1, ph);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_mode[0] = 0; m_to[0] = 8;
    m_mode[1] = 1; m_to[1] = 6;
    for (int d = 0; d < 2; d++) begin
      dly_min[d] = 0; dly_max[d] = 3;
    end
    do_reset("reset");

    // single request on ch2, ack a few clocks after req
    dly_min[0] = 2; dly_max[0] = 2;
    s_req[0] = 4'b0100; s_data[0] = 32'h00A5_0000;
    tick("t1");
    tick("t1");
    chk("t1.launch_req", 32'(bus0.dst_req), 32'd1);
    chk("t1.launch_ch", 32'(bus0.dst_ch), 32'd2);
    chk("t1.launch_data", 32'(bus0.dst_data), 32'hA5);
    run(12, "t1");
    chk("t1.ack_count", 32'(n_ack[0][2]), 32'd1);
    chk("t1.busy_clear", 32'(bus0.src_busy), 32'd0);

    // all four channels in one cycle
    do_reset("t2rst");
    dly_min[0] = 0; dly_max[0] = 3;
    s_req[0] = 4'b1111; s_data[0] = 32'h4433_2211;
    run(50, "t2");
    chk("t2.launches", 32'(q_ch0.size()), 32'd4);
    for (int k = 0; k < 4 && k < q_ch0.size(); k++) begin
      chk($sformatf("t2.order%0d", k), 32'(q_ch0[k]), 32'(k));
      chk($sformatf("t2.data%0d", k), 32'(q_data0[k]), 32'((k + 1) * 8'h11));
    end
    for (int i = 0; i < CH; i++) chk($sformatf("t2.ack%0d", i), 32'(n_ack[0][i]), 32'd1);

    // two-phase back-to-back transfers
    do_reset("t3rst");
    dly_min[1] = 0; dly_max[1] = 0;
    s_req[1] = 4'b0111; s_data[1] = 32'h0030_2010;
    run(14, "t3");
    chk("t3.launches", 32'(q_req1.size()), 32'd3);
    for (int k = 0; k < 3 && k < q_req1.size(); k++)
      chk($sformatf("t3.req_level%0d", k), 32'(q_req1[k]), 32'((k + 1) % 2));
    chk("t3.acks", 32'(n_ack[1][0] + n_ack[1][1] + n_ack[1][2]), 32'd3);

    // timeout with ack held low
    do_reset("t4rst");
    stall[0] = 1;
    s_req[0] = 4'b1000; s_data[0] = 32'h7700_0000;
    run(14, "t4");
    chk("t4.err_count", 32'(n_err[0][3]), 32'd1);
    chk("t4.ack_count", 32'(n_ack[0][3]), 32'd0);
    chk("t4.err_latency", 32'(t_err[0] - t_launch[0]), 32'd8);
    chk("t4.req_low", 32'(bus0.dst_req), 32'd0);
    chk("t4.busy_clear", 32'(bus0.src_busy), 32'd0);

    // second request while ch1 is in flight
    do_reset("t5rst");
    dly_min[0] = 4; dly_max[0] = 4;
    s_req[0] = 4'b0010; s_data[0] = 32'h0000_3C00;
    tick("t5");
    tick("t5");
    s_req[0] = 4'b0010; s_data[0] = 32'h0000_9900;
    tick("t5");
    run(14, "t5");
    chk("t5.ovf_count", 32'(n_ovf[0][1]), 32'd1);
    chk("t5.launches", 32'(q_data0.size()), 32'd1);
    if (q_data0.size() > 0) chk("t5.data", 32'(q_data0[0]), 32'h3C);
    chk("t5.ack_count", 32'(n_ack[0][1]), 32'd1);

    // asynchronous reset in REQ, then the pointer restarts at ch0
    do_reset("t6rst");
    stall[0] = 1;
    s_req[0] = 4'b0010; s_data[0] = 32'h0000_5A00;
    run(3, "t6");
    chk("t6.pre_req", 32'(bus0.dst_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6.rst_req", 32'(bus0.dst_req), 32'd0);
    chk("t6.rst_busy", 32'(bus0.src_busy), 32'd0);
    chk("t6.rst_data", 32'(bus0.dst_data), 32'd0);
    quiet_inputs();
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    s_req[0] = 4'b1001; s_data[0] = 32'hD100_00C0;
    tick("t6");
    tick("t6");
    chk("t6.first_grant", 32'(bus0.dst_ch), 32'd0);
    run(30, "t6");

    // randomized traffic on both instances
    do_reset("rndrst");
    dly_min[0] = 0; dly_max[0] = 10;
    dly_min[1] = 0; dly_max[1] = 8;
    for (int n = 0; n < 3000; n++) begin
      s_req[0]  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      s_req[1]  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      s_data[0] = $urandom;
      s_data[1] = $urandom;
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
